// File: rtl/osc_reset_sequencer_pkg.sv
// Shared types and constants for the oscillator reset sequencer.
// State encodings are visible on the STATE debug output.
package osc_reset_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_WAIT_OSC  = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_RELEASE   = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAULT     = 3'd4,
      ST_HOLD      = 3'd5
   } state_e;

   localparam int LLC_W      = 8;
   localparam int SYNC_DEPTH = 2;
   localparam int STAGE_W    = 3;

   function automatic logic [LLC_W-1:0] sat_inc(
      input logic [LLC_W-1:0] v
   );
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/osc_reset_sequencer_sync_2ff.sv
// Multi-flop synchronizer for a single asynchronous level.
// Clears to 0 on the asynchronous active-high reset.
module sync_2ff
   import osc_reset_sequencer_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic [SYNC_DEPTH-1:0] r_sync;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_DEPTH-2:0], i_d};
      end
   end

   assign o_q = r_sync[SYNC_DEPTH-1];

endmodule

// File: rtl/osc_reset_sequencer.sv
// Staged fabric reset sequencer with oscillator settle, lock filter
// and lock supervision; re-runs the release on lock loss or SW request.
module osc_reset_sequencer
   import osc_reset_sequencer_pkg::*;
#(
   parameter int STARTUP_CYCLES = 50000,
   parameter int N_STAGES       = 3,
   parameter int STAGE_GAP      = 256,
   parameter int LOCK_FILTER    = 16,
   parameter int CNT_W          = 16
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                PLL_LOCK,
   input  logic                SW_RESET_REQ,
   output logic [N_STAGES-1:0] FABRIC_RESET_N,
   output logic                READY,
   output logic [LLC_W-1:0]    LOCK_LOST_CNT,
   output logic [2:0]          STATE
);

   localparam logic [CNT_W-1:0] OSC_LAST =
      CNT_W'(STARTUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] FILT_LAST =
      CNT_W'(LOCK_FILTER - 1);
   localparam logic [CNT_W-1:0] GAP_LAST =
      CNT_W'(STAGE_GAP - 1);
   localparam logic [STAGE_W-1:0] LAST_STAGE =
      STAGE_W'(N_STAGES - 1);
   localparam logic [N_STAGES-1:0] FIRST_BIT =
      N_STAGES'(1);

   logic w_lock_s;

   state_e                r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [STAGE_W-1:0]    r_stage;
   logic [N_STAGES-1:0]   r_frn;
   logic                  r_ready;
   logic [LLC_W-1:0]      r_llc;

   state_e                w_state;
   logic [CNT_W-1:0]      w_cnt;
   logic [STAGE_W-1:0]    w_stage;
   logic [N_STAGES-1:0]   w_frn;
   logic                  w_ready;
   logic [LLC_W-1:0]      w_llc;

   sync_2ff u_lock_sync (
      .i_clk (CLK),
      .i_rst (RESET),
      .i_d   (PLL_LOCK),
      .o_q   (w_lock_s)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state <= ST_WAIT_OSC;
         r_cnt   <= '0;
         r_stage <= '0;
         r_frn   <= '0;
         r_ready <= 1'b0;
         r_llc   <= '0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_stage <= w_stage;
         r_frn   <= w_frn;
         r_ready <= w_ready;
         r_llc   <= w_llc;
      end
   end

   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_stage = r_stage;
      w_frn   = r_frn;
      w_ready = r_ready;
      w_llc   = r_llc;
      unique case (r_state)
         ST_WAIT_OSC: begin
            if (r_cnt == OSC_LAST) begin
               w_state = ST_WAIT_LOCK;
               w_cnt   = '0;
            end else begin
               w_cnt = r_cnt + 1'b1;
            end
         end
         ST_WAIT_LOCK: begin
            if (!w_lock_s) begin
               w_cnt = '0;
            end else if (r_cnt == FILT_LAST) begin
               w_state = ST_RELEASE;
               w_cnt   = '0;
               w_stage = '0;
               w_frn   = FIRST_BIT;
            end else begin
               w_cnt = r_cnt + 1'b1;
            end
         end
         // Lock loss outranks a simultaneous software request.
         ST_RELEASE, ST_RUN: begin
            if (!w_lock_s) begin
               w_state = ST_FAULT;
               w_frn   = '0;
               w_ready = 1'b0;
               w_llc   = sat_inc(r_llc);
            end else if (SW_RESET_REQ) begin
               w_state = ST_HOLD;
               w_cnt   = '0;
               w_frn   = '0;
               w_ready = 1'b0;
            end else if (r_state == ST_RELEASE) begin
               if (r_cnt == GAP_LAST) begin
                  w_cnt = '0;
                  if (r_stage == LAST_STAGE) begin
                     w_state = ST_RUN;
                     w_ready = 1'b1;
                  end else begin
                     w_stage = r_stage + 1'b1;
                     w_frn   = (r_frn << 1) | FIRST_BIT;
                  end
               end else begin
                  w_cnt = r_cnt + 1'b1;
               end
            end
         end
         ST_FAULT: begin
            w_state = ST_WAIT_LOCK;
            w_cnt   = '0;
         end
         ST_HOLD: begin
            if (r_cnt == GAP_LAST) begin
               w_state = ST_WAIT_LOCK;
               w_cnt   = '0;
            end else begin
               w_cnt = r_cnt + 1'b1;
            end
         end
         default: begin
            // Illegal encoding: recover like a fault, without counting.
            w_state = ST_FAULT;
            w_cnt   = '0;
            w_frn   = '0;
            w_ready = 1'b0;
         end
      endcase
   end

   assign FABRIC_RESET_N = r_frn;
   assign READY          = r_ready;
   assign LOCK_LOST_CNT  = r_llc;
   assign STATE          = r_state;

endmodule
